// File: rtl/instr_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// instr_mem_arbiter_pkg : sizing, NOP word, FSM encoding, boot program image
// Revision: 1.0
// ============================================================================
package instr_mem_arbiter_pkg;

   localparam int DEPTH  = 128;
   localparam int ADDR_W = 7;

   localparam logic [31:0] NOP = 32'h0000_0000;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_LOAD   = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   // Boot image: word 1 is the fixed reset-vector target, the rest are tagged MOVs.
   function automatic logic [31:0] default_word(input int idx);
      logic [31:0] w;
      if (idx == 1) w = 32'hE002_0191;
      else          w = 32'hE1A0_0000 | 32'(idx);
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// ============================================================================
// instr_ram : instruction storage, one synchronous write, one async read port
// Revision: 1.0
// ============================================================================
module instr_ram #(
   parameter int DEPTH  = instr_mem_arbiter_pkg::DEPTH,
   parameter int ADDR_W = instr_mem_arbiter_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);
   import instr_mem_arbiter_pkg::*;

   logic [31:0] words [DEPTH];

   // Per-word registers so each can carry its boot-image value; no reset on contents.
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      logic [31:0] word = default_word(g);

      always_ff @(posedge clk) begin
         if (we && (waddr == ADDR_W'(g))) begin
            word <= wdata;
         end
      end

      assign words[g] = word;
   end

   assign rdata = words[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// instr_mem_arbiter : core fetch port vs. program loader ownership of imem
// Revision: 1.0
// ============================================================================
module instr_mem_arbiter #(
   parameter int DEPTH  = instr_mem_arbiter_pkg::DEPTH,
   parameter int ADDR_W = instr_mem_arbiter_pkg::ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       PC,
   output logic [31:0]       Instr,
   output logic              StallF,
   output logic              CoreReset,
   input  logic              LoadReq,
   input  logic              LoadValid,
   input  logic [31:0]       LoadData,
   input  logic              LoadLast,
   output logic              LoadReady,
   output logic              LoadDone,
   output logic              LoadErr,
   output logic [ADDR_W:0]   WordCount
);
   import instr_mem_arbiter_pkg::*;

   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   word_count;
   logic              load_err;
   logic              accept;
   logic              pc_in_range;
   logic [31:0]       ram_rdata;
   logic              unused_pc_bits;

   assign accept = (state == ST_LOAD) && LoadValid;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_RUN;
         ptr        <= '0;
         word_count <= '0;
         load_err   <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (LoadReq) begin
                  state      <= ST_DRAIN;
                  ptr        <= '0;
                  word_count <= '0;
                  load_err   <= 1'b0;
               end
            end
            ST_DRAIN: begin
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (accept) begin
                  ptr        <= ptr + 1'b1;
                  word_count <= word_count + 1'b1;
                  if (LoadLast) begin
                     state <= ST_FINISH;
                  end else if (ptr == ADDR_W'(DEPTH - 1)) begin
                     // Last slot filled without LoadLast: flag overflow, stop writing.
                     load_err <= 1'b1;
                     state    <= ST_FINISH;
                  end
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   instr_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_instr_ram (
      .clk   (CLK),
      .we    (accept),
      .waddr (ptr),
      .wdata (LoadData),
      .raddr (PC[ADDR_W+1:2]),
      .rdata (ram_rdata)
   );

   assign pc_in_range    = (PC[31:ADDR_W+2] == '0);
   assign unused_pc_bits = ^PC[1:0];

   assign Instr     = ((state == ST_RUN) && pc_in_range) ? ram_rdata : NOP;
   assign StallF    = (state != ST_RUN);
   assign LoadReady = (state == ST_LOAD);
   assign LoadDone  = (state == ST_FINISH);
   assign CoreReset = (state == ST_FINISH);
   assign LoadErr   = load_err;
   assign WordCount = word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_instr_mem_arbiter : directed + randomized bench against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_instr_mem_arbiter;

   localparam int MDEPTH = 128;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        StallF;
   logic        CoreReset;
   logic        LoadReq;
   logic        LoadValid;
   logic [31:0] LoadData;
   logic        LoadLast;
   logic        LoadReady;
   logic        LoadDone;
   logic        LoadErr;
   logic [7:0]  WordCount;

   int n_total = 0;
   int n_pass  = 0;

   instr_mem_arbiter dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .PC        (PC),
      .Instr     (Instr),
      .StallF    (StallF),
      .CoreReset (CoreReset),
      .LoadReq   (LoadReq),
      .LoadValid (LoadValid),
      .LoadData  (LoadData),
      .LoadLast  (LoadLast),
      .LoadReady (LoadReady),
      .LoadDone  (LoadDone),
      .LoadErr   (LoadErr),
      .WordCount (WordCount)
   );

   always #5 CLK = ~CLK;

   // Model: phase 0 fetching, 1 one idle stall cycle, 2 taking words, 3 one finish cycle.
   int          m_phase = 0;
   int          m_count = 0;
   bit          m_err   = 1'b0;
   logic [31:0] m_mem [MDEPTH];

   initial begin
      for (int i = 0; i < MDEPTH; i++) begin
         m_mem[i] = (i == 1) ? 32'hE002_0191 : (32'hE1A0_0000 + 32'(i));
      end
   end

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_phase <= 0;
         m_count <= 0;
         m_err   <= 1'b0;
      end else if (m_phase == 0) begin
         if (LoadReq) begin
            m_phase <= 1;
            m_count <= 0;
            m_err   <= 1'b0;
         end
      end else if (m_phase == 1) begin
         m_phase <= 2;
      end else if (m_phase == 2) begin
         if (LoadValid) begin
            m_mem[m_count] <= LoadData;
            m_count        <= m_count + 1;
            if (LoadLast) begin
               m_phase <= 3;
            end else if (m_count + 1 == MDEPTH) begin
               m_err   <= 1'b1;
               m_phase <= 3;
            end
         end
      end else begin
         m_phase <= 0;
      end
   end

   function automatic logic [31:0] exp_instr(input logic [31:0] pc);
      if (m_phase != 0)      return 32'h0;
      if (pc >= 32'd512)     return 32'h0;
      return m_mem[pc[8:2]];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge CLK) begin
      chk("m_instr",     Instr,            exp_instr(PC));
      chk("m_stallf",    32'(StallF),      32'(m_phase != 0));
      chk("m_ready",     32'(LoadReady),   32'(m_phase == 2));
      chk("m_done",      32'(LoadDone),    32'(m_phase == 3));
      chk("m_corereset", 32'(CoreReset),   32'(m_phase == 3));
      chk("m_err",       32'(LoadErr),     32'(m_err));
      chk("m_count",     32'(WordCount),   32'(m_count));
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic v, input logic [31:0] d, input logic l);
      LoadValid = v;
      LoadData  = d;
      LoadLast  = l;
      step();
   endtask

   initial begin
      RESET = 1'b1; PC = 32'h0; LoadReq = 1'b0;
      LoadValid = 1'b0; LoadData = 32'h0; LoadLast = 1'b0;
      step();
      @(negedge CLK);
      chk("rst_stallf",    32'(StallF),    32'h0);
      chk("rst_ready",     32'(LoadReady), 32'h0);
      chk("rst_done",      32'(LoadDone),  32'h0);
      chk("rst_corereset", 32'(CoreReset), 32'h0);
      chk("rst_err",       32'(LoadErr),   32'h0);
      chk("rst_count",     32'(WordCount), 32'h0);
      step();
      RESET = 1'b0;

      PC = 32'h4; #1;
      chk("pc4_instr",  Instr,        32'hE002_0191);
      chk("pc4_stallf", 32'(StallF),  32'h0);
      PC = 32'h400; #1;
      chk("pc400_instr", Instr, 32'h0);
      PC = 32'hC; #1;
      chk("pc12_instr", Instr, 32'hE1A0_0003);

      // Three-word load with one idle gap (LoadLast without LoadValid in the gap).
      step();
      LoadReq = 1'b1;
      step();
      LoadReq = 1'b0;
      @(negedge CLK);
      chk("ld_drain_stallf", 32'(StallF),    32'h1);
      chk("ld_drain_ready",  32'(LoadReady), 32'h0);
      step();
      @(negedge CLK);
      chk("ld_ready_2cyc", 32'(LoadReady), 32'h1);
      send(1'b1, 32'hE59F_1208, 1'b0);
      send(1'b0, 32'h1234_5678, 1'b1);
      send(1'b1, 32'hE3A0_9000, 1'b0);
      send(1'b1, 32'hEAFF_FFFE, 1'b1);
      LoadValid = 1'b0; LoadLast = 1'b0;
      @(negedge CLK);
      chk("ld_done",      32'(LoadDone),  32'h1);
      chk("ld_corereset", 32'(CoreReset), 32'h1);
      chk("ld_count",     32'(WordCount), 32'd3);
      chk("ld_err",       32'(LoadErr),   32'h0);
      step();
      @(negedge CLK);
      chk("ld_done_pulse",  32'(LoadDone),  32'h0);
      chk("ld_crst_pulse",  32'(CoreReset), 32'h0);
      chk("ld_run_stallf",  32'(StallF),    32'h0);
      PC = 32'h8; #1;
      chk("ld_pc8", Instr, 32'hEAFF_FFFE);
      PC = 32'h1FC; #1;
      chk("ld_pc508_kept", Instr, 32'hE1A0_007F);
      for (int i = 0; i < MDEPTH; i++) begin
         PC = 32'(i * 4);
         step();
      end

      // Overflow: 128 words without LoadLast, LoadReq held high throughout.
      LoadReq = 1'b1;
      step();
      step();
      for (int i = 0; i < MDEPTH; i++) begin
         send(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
      end
      LoadData = 32'hDEAD_BEEF;
      @(negedge CLK);
      chk("ov_err",    32'(LoadErr),   32'h1);
      chk("ov_count",  32'(WordCount), 32'd128);
      chk("ov_ready",  32'(LoadReady), 32'h0);
      chk("ov_finish", 32'(LoadDone),  32'h1);
      step();
      LoadValid = 1'b0;
      @(negedge CLK);
      chk("ov_run_stallf", 32'(StallF),    32'h0);
      chk("ov_err_sticky", 32'(LoadErr),   32'h1);
      chk("ov_count_kept", 32'(WordCount), 32'd128);
      PC = 32'h0; #1;
      chk("ov_mem0", Instr, 32'hC000_0000);
      step();
      @(negedge CLK);
      chk("rq_drain_stallf", 32'(StallF),    32'h1);
      chk("rq_err_cleared",  32'(LoadErr),   32'h0);
      chk("rq_count_clr",    32'(WordCount), 32'h0);
      LoadReq = 1'b0;
      step();

      // Reset after two of five words aborts the load.
      send(1'b1, 32'hA000_0001, 1'b0);
      send(1'b1, 32'hA000_0002, 1'b0);
      LoadData = 32'hA000_0003;
      RESET = 1'b1; #1;
      chk("ab_stallf",    32'(StallF),    32'h0);
      chk("ab_ready",     32'(LoadReady), 32'h0);
      chk("ab_done",      32'(LoadDone),  32'h0);
      chk("ab_corereset", 32'(CoreReset), 32'h0);
      PC = 32'h0; #1;
      chk("ab_mem0", Instr, 32'hA000_0001);
      PC = 32'h4; #1;
      chk("ab_mem1", Instr, 32'hA000_0002);
      PC = 32'h8; #1;
      chk("ab_mem2", Instr, 32'hC000_0002);
      step();
      RESET = 1'b0; LoadValid = 1'b0;
      step();

      for (int n = 0; n < 3000; n++) begin
         PC        = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 511));
         LoadReq   = ($urandom_range(0, 19) == 0);
         LoadValid = ($urandom_range(0, 9) < 6);
         LoadLast  = ($urandom_range(0, 15) == 0);
         LoadData  = $urandom;
         RESET     = ($urandom_range(0, 199) == 0);
         step();
      end
      RESET = 1'b0; LoadReq = 1'b0; LoadValid = 1'b0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 128, number of 32-bit instruction words held.
REQ-002 Parameter ADDR_W, default 7, word-address width, equal to log2(DEPTH).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 PC  input  32  fetch byte address from the core.
REQ-006 Instr  output  32  fetched instruction word to the core.
REQ-007 StallF  output  1  high while the memory is owned by the loader; the core holds PC.
REQ-008 CoreReset  output  1  one-cycle pulse that restarts the core after a completed load.
REQ-009 LoadReq  input  1  loader requests ownership of the memory.
REQ-010 LoadValid  input  1  LoadData holds a valid word.
REQ-011 LoadData  input  32  program word to write.
REQ-012 LoadLast  input  1  qualifies the final word of the program when LoadValid is high.
REQ-013 LoadReady  output  1  arbiter accepts a word this cycle.
REQ-014 LoadDone  output  1  one-cycle pulse when a load completes.
REQ-015 LoadErr  output  1  sticky flag: the program overflowed DEPTH words.
REQ-016 WordCount  output  ADDR_W+1  number of words written by the current or last load.

Function
REQ-017 The FSM SHALL have exactly four states: RUN, DRAIN, LOAD, FINISH.
REQ-018 RUN: StallF=0 and Instr = mem[PC[ADDR_W+1:2]], combinational, zero latency; PC[1:0] ignored.
REQ-019 RUN: Instr SHALL be 32'h0 when PC[31:ADDR_W+2] is nonzero (out of range).
REQ-020 RUN with LoadReq=1 SHALL go to DRAIN next cycle, clear WordCount and LoadErr, and zero the write pointer.
REQ-021 DRAIN: StallF=1, Instr=32'h0, LoadReady=0; unconditional transition to LOAD next cycle.
REQ-022 LOAD: StallF=1, Instr=32'h0, LoadReady=1.
REQ-023 LOAD: each cycle with LoadValid=1 SHALL write mem[ptr]=LoadData at the clock edge and increment ptr and WordCount.
REQ-024 LOAD: an accepted word with LoadLast=1 SHALL go to FINISH.
REQ-025 LOAD: acceptance of word index DEPTH-1 with LoadLast=0 SHALL set LoadErr and go to FINISH; no word is ever written past DEPTH-1.
REQ-026 LOAD: LoadValid=0 SHALL hold state indefinitely (no timeout).
REQ-027 FINISH: StallF=1, CoreReset=1, LoadDone=1 for exactly one cycle, then RUN.
REQ-028 LoadReq SHALL be ignored outside RUN; a LoadReq held high through FINISH starts a new load from RUN.
REQ-029 LoadLast together with LoadValid=0 SHALL have no effect.
REQ-030 Memory SHALL have one synchronous write port and one asynchronous read port; no read-during-write hazard arises because fetch is stalled during LOAD.
REQ-031 Words not overwritten by a load SHALL retain their previous contents.

Reset
REQ-032 RESET SHALL force RUN with ptr=0, WordCount=0, LoadErr=0, and StallF, CoreReset, LoadDone and LoadReady all 0, independent of CLK.
REQ-033 RESET SHALL NOT clear memory contents; the initial image comes from the package default program at elaboration.
REQ-034 RESET asserted mid-load SHALL abort the load: partial contents remain, no LoadDone, and no CoreReset pulse.

Structure
REQ-035 The shared package SHALL hold DEPTH, ADDR_W, NOP word 32'h0, the FSM state encoding and the default program image.
REQ-036 Storage SHALL be one sub-module, instr_ram (1 write port, 1 async read port); FSM, pointer and flags live in instr_mem_arbiter.

Verification
REQ-037 After reset, PC=0x4 with mem[1]=0xE0020191 -> Instr=0xE0020191 in the same cycle, StallF=0.
REQ-038 PC=0x400 -> Instr=0x00000000.
REQ-039 LoadReq pulse, then 3 words 0xE59F1208, 0xE3A09000 and 0xEAFFFFFE (the last with LoadLast), with one idle LoadValid=0 gap:
- StallF high from the cycle after the LoadReq edge.
- LoadReady first high 2 cycles after the LoadReq edge.
- WordCount=3, LoadErr=0.
- Single-cycle LoadDone and CoreReset.
- Then PC=0x8 reads 0xEAFFFFFE.
- mem[3..127] unchanged.
REQ-040 Stream 128 words without LoadLast:
- LoadErr=1 after word 127 is accepted; WordCount=128; FINISH entered.
- A 129th LoadValid is not accepted (LoadReady=0) and mem[0] is not overwritten.
REQ-041 RESET asserted after 2 of 5 load words -> RUN immediately, StallF=0, no LoadDone, mem[0..1] hold the new words, mem[2] holds the old value.
REQ-042 LoadReq asserted during LOAD and FINISH -> no restart and WordCount unaffected; LoadReq held into RUN -> DRAIN next cycle and LoadErr cleared.
